// File: rtl/turf_udp_hsk_spi_rx_if.sv
// rtl/turf_udp_hsk_spi_rx_if.sv - UDP header and payload stream bundle for the SPI housekeeping receiver
interface turf_udp_hsk_spi_rx_if #(
  parameter int DATA_BYTES = 8
) ();
  logic [63:0]             m_udphdr_tdata;
  logic                    m_udphdr_tvalid;
  logic                    m_udphdr_tready;
  logic [8*DATA_BYTES-1:0] m_udpdata_tdata;
  logic [DATA_BYTES-1:0]   m_udpdata_tkeep;
  logic                    m_udpdata_tlast;
  logic                    m_udpdata_tvalid;
  logic                    m_udpdata_tready;

  modport master (
    output m_udphdr_tdata, m_udphdr_tvalid,
    input  m_udphdr_tready,
    output m_udpdata_tdata, m_udpdata_tkeep, m_udpdata_tlast, m_udpdata_tvalid,
    input  m_udpdata_tready
  );

  modport slave (
    input  m_udphdr_tdata, m_udphdr_tvalid,
    output m_udphdr_tready,
    input  m_udpdata_tdata, m_udpdata_tkeep, m_udpdata_tlast, m_udpdata_tvalid,
    output m_udpdata_tready
  );
endinterface

// File: rtl/turf_udp_hsk_spi_rx.sv
// rtl/turf_udp_hsk_spi_rx.sv - SPI slave to UDP header/payload streams with commit/rollback buffering
module turf_udp_hsk_spi_rx #(
  parameter int DATA_BYTES  = 8,
  parameter int DATA_DEPTH  = 512,
  parameter int HDR_DEPTH   = 16,
  parameter int MAX_PAYLOAD = 1024,
  parameter bit SAMPLE_FALL = 1'b0
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        cs_b,
  input  logic [15:0] ip_i,
  input  logic [15:0] port_i,
  turf_udp_hsk_spi_rx_if.master m_axis,
  output logic [15:0] pkt_count,
  output logic [15:0] drop_count
);

  localparam int AW  = $clog2(DATA_DEPTH);
  localparam int HAW = $clog2(HDR_DEPTH);
  localparam int LW  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int BCW = $clog2(MAX_PAYLOAD + 1) + 1;
  localparam int WW  = DATA_BYTES + 8 * DATA_BYTES;

  localparam logic [2:0] S_WAIT_IDLE = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_RECV      = 3'd2;
  localparam logic [2:0] S_FLUSH     = 3'd3;
  localparam logic [2:0] S_COMMIT    = 3'd4;
  localparam logic [2:0] S_DROP      = 3'd5;

  // Synchronisers: [0],[1] resolve metastability, [2] holds the previous value for edge detection.
  logic [2:0] sclk_s_q, cs_s_q;
  logic [1:0] mosi_s_q;

  logic [2:0]              state_q, state_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [7:0]              shift_q, shift_d;
  logic [BCW-1:0]          byte_cnt_q, byte_cnt_d;
  logic [LW-1:0]           lane_q, lane_d;
  logic [8*DATA_BYTES-1:0] pack_q, pack_d;
  logic [AW:0]             wr_spec_q, wr_spec_d;
  logic [AW:0]             commit_q, commit_d;
  logic [AW:0]             rd_q, rd_d;
  logic [HAW:0]            hdr_wr_q, hdr_wr_d;
  logic [HAW:0]            hdr_rd_q, hdr_rd_d;
  logic [15:0]             pkt_q, pkt_d;
  logic [15:0]             drop_q, drop_d;
  logic                    drop_done_q, drop_done_d;

  logic [WW-1:0] data_mem_q [DATA_DEPTH];
  logic          tlast_mem_q [DATA_DEPTH];
  logic [47:0]   hdr_mem_q [HDR_DEPTH];

  logic                    mem_we, tl_we, tl_wdata, hdr_we;
  logic [AW-1:0]           mem_waddr, tl_waddr;
  logic [WW-1:0]           mem_wdata;
  logic [47:0]             hdr_wdata;
  logic [7:0]              new_byte;
  logic [8*DATA_BYTES-1:0] word;
  logic [DATA_BYTES-1:0]   keep_part;
  logic                    cs_s, cs_fall, cs_rise, sclk_edge, data_full, hdr_full;
  logic                    data_valid, hdr_valid;

  assign cs_s      = cs_s_q[1];
  assign cs_fall   = !cs_s_q[1] && cs_s_q[2];
  assign cs_rise   = cs_s_q[1] && !cs_s_q[2];
  assign sclk_edge = SAMPLE_FALL ? (!sclk_s_q[1] && sclk_s_q[2]) : (sclk_s_q[1] && !sclk_s_q[2]);
  assign new_byte  = {shift_q[6:0], mosi_s_q[1]};
  // Full when the pointers address the same slot but sit on different laps.
  assign data_full = (wr_spec_q[AW] != rd_q[AW]) && (wr_spec_q[AW-1:0] == rd_q[AW-1:0]);
  assign hdr_full  = (hdr_wr_q[HAW] != hdr_rd_q[HAW]) && (hdr_wr_q[HAW-1:0] == hdr_rd_q[HAW-1:0]);
  // Only committed words are visible to the consumer.
  assign data_valid = (rd_q != commit_q);
  assign hdr_valid  = (hdr_rd_q != hdr_wr_q);

  // Place the just-completed byte into its lane and build the keep mask of a partial word.
  always_comb begin
    word      = pack_q;
    keep_part = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (lane_q == LW'(i)) word[8*i +: 8] = new_byte;
      keep_part[i] = (LW'(i) < lane_q);
    end
  end

  // Packet FSM, buffer write control and stream pointer advance.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_cnt_d  = byte_cnt_q;
    lane_d      = lane_q;
    pack_d      = pack_q;
    wr_spec_d   = wr_spec_q;
    commit_d    = commit_q;
    rd_d        = rd_q;
    hdr_wr_d    = hdr_wr_q;
    hdr_rd_d    = hdr_rd_q;
    pkt_d       = pkt_q;
    drop_d      = drop_q;
    drop_done_d = drop_done_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_spec_q[AW-1:0];
    mem_wdata   = {{DATA_BYTES{1'b1}}, word};
    tl_we       = 1'b0;
    tl_waddr    = wr_spec_q[AW-1:0];
    tl_wdata    = 1'b0;
    hdr_we      = 1'b0;
    hdr_wdata   = {ip_i, port_i, 16'(byte_cnt_q) + 16'd8};
    case (state_q)
      S_WAIT_IDLE: if (cs_s) state_d = S_IDLE;
      S_IDLE: begin
        if (cs_fall) begin
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          lane_d     = '0;
          pack_d     = '0;
          shift_d    = '0;
          state_d    = S_RECV;
        end
      end
      S_RECV: begin
        if (cs_rise) begin
          if (bit_cnt_q != 3'd0)        state_d = S_DROP;
          else if (byte_cnt_q == '0)    state_d = S_IDLE;
          else                          state_d = S_FLUSH;
        end else if (sclk_edge) begin
          shift_d   = new_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (byte_cnt_q == BCW'(MAX_PAYLOAD)) begin
              state_d = S_DROP;
            end else begin
              byte_cnt_d = byte_cnt_q + BCW'(1);
              if (lane_q == LW'(DATA_BYTES - 1)) begin
                if (data_full) begin
                  state_d = S_DROP;
                end else begin
                  mem_we    = 1'b1;
                  tl_we     = 1'b1;
                  wr_spec_d = wr_spec_q + 1'b1;
                  pack_d    = '0;
                  lane_d    = '0;
                end
              end else begin
                pack_d = word;
                lane_d = lane_q + LW'(1);
              end
            end
          end
        end
      end
      S_FLUSH: begin
        // A packet ending on a word boundary already wrote its last word; only its tlast is set here.
        if (lane_q != '0) begin
          if (data_full) begin
            state_d = S_DROP;
          end else begin
            mem_we    = 1'b1;
            mem_wdata = {keep_part, pack_q};
            tl_we     = 1'b1;
            tl_wdata  = 1'b1;
            wr_spec_d = wr_spec_q + 1'b1;
            state_d   = S_COMMIT;
          end
        end else begin
          tl_we    = 1'b1;
          tl_waddr = wr_spec_q[AW-1:0] - AW'(1);
          tl_wdata = 1'b1;
          state_d  = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (hdr_full) begin
          state_d = S_DROP;
        end else begin
          hdr_we   = 1'b1;
          hdr_wr_d = hdr_wr_q + 1'b1;
          commit_d = wr_spec_q;
          pkt_d    = pkt_q + 16'd1;
          state_d  = S_IDLE;
        end
      end
      S_DROP: begin
        if (!drop_done_q) begin
          wr_spec_d   = commit_q;
          drop_d      = drop_q + 16'd1;
          drop_done_d = 1'b1;
        end
        if (cs_s) begin
          drop_done_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_WAIT_IDLE;
    endcase
    if (data_valid && m_axis.m_udpdata_tready) rd_d = rd_q + 1'b1;
    if (hdr_valid && m_axis.m_udphdr_tready)   hdr_rd_d = hdr_rd_q + 1'b1;
  end

  // State, pointers, counters and synchronisers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sclk_s_q    <= '0;
      cs_s_q      <= '0;
      mosi_s_q    <= '0;
      state_q     <= S_WAIT_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      byte_cnt_q  <= '0;
      lane_q      <= '0;
      pack_q      <= '0;
      wr_spec_q   <= '0;
      commit_q    <= '0;
      rd_q        <= '0;
      hdr_wr_q    <= '0;
      hdr_rd_q    <= '0;
      pkt_q       <= '0;
      drop_q      <= '0;
      drop_done_q <= 1'b0;
    end else begin
      sclk_s_q    <= {sclk_s_q[1:0], sclk};
      cs_s_q      <= {cs_s_q[1:0], cs_b};
      mosi_s_q    <= {mosi_s_q[0], mosi};
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_cnt_q  <= byte_cnt_d;
      lane_q      <= lane_d;
      pack_q      <= pack_d;
      wr_spec_q   <= wr_spec_d;
      commit_q    <= commit_d;
      rd_q        <= rd_d;
      hdr_wr_q    <= hdr_wr_d;
      hdr_rd_q    <= hdr_rd_d;
      pkt_q       <= pkt_d;
      drop_q      <= drop_d;
      drop_done_q <= drop_done_d;
    end
  end

  // Buffer storage; contents need no reset because pointers gate visibility.
  always_ff @(posedge aclk) begin
    if (mem_we) data_mem_q[mem_waddr] <= mem_wdata;
    if (tl_we)  tlast_mem_q[tl_waddr] <= tl_wdata;
    if (hdr_we) hdr_mem_q[hdr_wr_q[HAW-1:0]] <= hdr_wdata;
  end

  logic [WW-1:0] rd_word;
  logic [47:0]   hdr_word;
  assign rd_word  = data_mem_q[rd_q[AW-1:0]];
  assign hdr_word = hdr_mem_q[hdr_rd_q[HAW-1:0]];

  assign m_axis.m_udpdata_tvalid = data_valid;
  assign m_axis.m_udpdata_tdata  = data_valid ? rd_word[8*DATA_BYTES-1:0] : '0;
  assign m_axis.m_udpdata_tkeep  = data_valid ? rd_word[WW-1:8*DATA_BYTES] : '0;
  assign m_axis.m_udpdata_tlast  = data_valid && tlast_mem_q[rd_q[AW-1:0]];
  assign m_axis.m_udphdr_tvalid  = hdr_valid;
  assign m_axis.m_udphdr_tdata   = hdr_valid ? {hdr_word[47:16], 16'h0, hdr_word[15:0]} : '0;
  assign pkt_count  = pkt_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_turf_udp_hsk_spi_rx.sv
// tb/tb_turf_udp_hsk_spi_rx.sv - directed self-checking bench for turf_udp_hsk_spi_rx
module tb_turf_udp_hsk_spi_rx;
  localparam int HALF = 5;

  logic aclk = 1'b0;
  logic areset, sclk, mosi, cs_b;
  logic [15:0] ip_i, port_i, pkt_count, drop_count;
  int checks = 0;
  int failures = 0;

  logic [63:0] hdr_q[$];
  logic [72:0] dat_q[$];
  logic [72:0] exp_q[$];
  logic [7:0]  tx[$];

  turf_udp_hsk_spi_rx_if #(.DATA_BYTES(8)) bus ();

  turf_udp_hsk_spi_rx #(
    .DATA_BYTES(8), .DATA_DEPTH(16), .HDR_DEPTH(4), .MAX_PAYLOAD(64), .SAMPLE_FALL(1'b0)
  ) dut (
    .aclk(aclk), .areset(areset), .sclk(sclk), .mosi(mosi), .cs_b(cs_b),
    .ip_i(ip_i), .port_i(port_i), .m_axis(bus),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) begin
    if (!areset) begin
      if (bus.m_udphdr_tvalid && bus.m_udphdr_tready) hdr_q.push_back(bus.m_udphdr_tdata);
      if (bus.m_udpdata_tvalid && bus.m_udpdata_tready)
        dat_q.push_back({bus.m_udpdata_tlast, bus.m_udpdata_tkeep, bus.m_udpdata_tdata});
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic b);
    mosi = b;
    repeat (HALF) @(negedge aclk);
    sclk = 1'b1;
    repeat (HALF) @(negedge aclk);
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] v);
    for (int k = 7; k >= 0; k--) spi_bit(v[k]);
  endtask

  task automatic spi_packet(input int extra_bits);
    cs_b = 1'b0;
    repeat (HALF) @(negedge aclk);
    foreach (tx[i]) spi_byte(tx[i]);
    for (int k = 0; k < extra_bits; k++) spi_bit(k[0]);
    repeat (HALF) @(negedge aclk);
    cs_b = 1'b1;
    repeat (12) @(negedge aclk);
  endtask

  // Reference packer: first byte in the low lane, tkeep contiguous, tlast on the final word.
  task automatic model_words();
    logic [63:0] w;
    logic [7:0]  kp;
    for (int i = 0; i < tx.size(); i += 8) begin
      w  = '0;
      kp = '0;
      for (int j = 0; j < 8; j++) begin
        if (i + j < tx.size()) begin
          w[8*j +: 8] = tx[i+j];
          kp[j] = 1'b1;
        end
      end
      exp_q.push_back({(i + 8 >= tx.size()), kp, w});
    end
  endtask

  task automatic wait_out(input int nh, input int nd, input string tag);
    int n = 0;
    while ((hdr_q.size() < nh || dat_q.size() < nd) && n < 500) begin
      @(negedge aclk);
      n++;
    end
    repeat (10) @(negedge aclk);
    check({tag, "_nhdr"}, hdr_q.size(), nh);
    check({tag, "_ndat"}, dat_q.size(), nd);
  endtask

  task automatic clear_q();
    hdr_q.delete();
    dat_q.delete();
    exp_q.delete();
  endtask

  initial begin
    areset = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    cs_b = 1'b1;
    ip_i = 16'hC0A8;
    port_i = 16'h1234;
    bus.m_udphdr_tready = 1'b1;
    bus.m_udpdata_tready = 1'b1;
    repeat (3) @(negedge aclk);
    check("rst_hdr_tvalid", bus.m_udphdr_tvalid, 0);
    check("rst_dat_tvalid", bus.m_udpdata_tvalid, 0);
    check("rst_dat_tdata", bus.m_udpdata_tdata, 0);
    check("rst_hdr_tdata", bus.m_udphdr_tdata, 0);
    check("rst_pkt", pkt_count, 0);
    check("rst_drop", drop_count, 0);
    areset = 1'b0;
    repeat (10) @(negedge aclk);

    // 16 bytes 00..0F
    tx.delete();
    for (int k = 0; k < 16; k++) tx.push_back(8'(k));
    spi_packet(0);
    wait_out(1, 2, "t1");
    check("t1_hdr", hdr_q[0], 64'hC0A8_1234_0000_0018);
    check("t1_w0", dat_q[0], {1'b0, 8'hFF, 64'h0706_0504_0302_0100});
    check("t1_w1", dat_q[1], {1'b1, 8'hFF, 64'h0F0E_0D0C_0B0A_0908});
    check("t1_pkt", pkt_count, 1);
    clear_q();

    // 3 bytes AA BB CC
    ip_i = 16'h0A00;
    port_i = 16'h5678;
    tx.delete();
    tx.push_back(8'hAA); tx.push_back(8'hBB); tx.push_back(8'hCC);
    spi_packet(0);
    wait_out(1, 1, "t2");
    check("t2_hdr", hdr_q[0], 64'h0A00_5678_0000_000B);
    check("t2_w0", dat_q[0], {1'b1, 8'h07, 64'h0000_0000_00CC_BBAA});
    clear_q();

    // 13 bits then cs rise: dropped
    tx.delete();
    tx.push_back(8'h55);
    spi_packet(5);
    repeat (20) @(negedge aclk);
    check("t3_nhdr", hdr_q.size(), 0);
    check("t3_ndat", dat_q.size(), 0);
    check("t3_drop", drop_count, 1);
    check("t3_pkt", pkt_count, 2);
    tx.delete();
    tx.push_back(8'h11); tx.push_back(8'h22); tx.push_back(8'h33);
    tx.push_back(8'h44); tx.push_back(8'h55);
    spi_packet(0);
    wait_out(1, 1, "t3b");
    check("t3b_hdr", hdr_q[0], 64'h0A00_5678_0000_000D);
    check("t3b_w0", dat_q[0], {1'b1, 8'h1F, 64'h0000_0055_4433_2211});
    check("t3b_pkt", pkt_count, 3);
    clear_q();

    // MAX_PAYLOAD+1 bytes dropped, then an 8-byte packet
    tx.delete();
    for (int k = 0; k < 65; k++) tx.push_back(8'(k + 3));
    spi_packet(0);
    check("t4_drop", drop_count, 2);
    tx.delete();
    for (int k = 0; k < 8; k++) tx.push_back(8'(8'h80 + k));
    spi_packet(0);
    wait_out(1, 1, "t4");
    check("t4_hdr", hdr_q[0], 64'h0A00_5678_0000_0010);
    check("t4_w0", dat_q[0], {1'b1, 8'hFF, 64'h8786_8584_8382_8180});
    check("t4_pkt", pkt_count, 4);
    clear_q();

    // Fill the 16-word buffer with tready low, then overflow
    @(posedge aclk);
    #1 bus.m_udpdata_tready = 1'b0;
    tx.delete();
    for (int k = 0; k < 64; k++) tx.push_back(8'(k));
    model_words();
    spi_packet(0);
    tx.delete();
    for (int k = 0; k < 64; k++) tx.push_back(8'(8'hFF - k));
    model_words();
    spi_packet(0);
    check("t5_pkt", pkt_count, 6);
    check("t5_stall_valid", bus.m_udpdata_tvalid, 1);
    check("t5_stall_word", {bus.m_udpdata_tlast, bus.m_udpdata_tkeep, bus.m_udpdata_tdata},
          {1'b0, 8'hFF, 64'h0706_0504_0302_0100});
    tx.delete();
    for (int k = 0; k < 8; k++) tx.push_back(8'(8'h30 + k));
    spi_packet(0);
    check("t5_drop", drop_count, 3);
    check("t5_pkt2", pkt_count, 6);
    check("t5_stable_word", {bus.m_udpdata_tlast, bus.m_udpdata_tkeep, bus.m_udpdata_tdata},
          {1'b0, 8'hFF, 64'h0706_0504_0302_0100});
    @(posedge aclk);
    #1 bus.m_udpdata_tready = 1'b1;
    wait_out(2, 16, "t5");
    check("t5_hdr0", hdr_q[0], 64'h0A00_5678_0000_0048);
    check("t5_hdr1", hdr_q[1], 64'h0A00_5678_0000_0048);
    for (int i = 0; i < 16; i++) begin
      if (i < dat_q.size()) check($sformatf("t5_w%0d", i), dat_q[i], exp_q[i]);
    end
    clear_q();

    // areset pulsed mid-packet with cs_b low
    cs_b = 1'b0;
    repeat (HALF) @(negedge aclk);
    spi_byte(8'h01); spi_byte(8'h02); spi_byte(8'h03);
    areset = 1'b1;
    repeat (2) @(negedge aclk);
    check("t6_rst_pkt", pkt_count, 0);
    check("t6_rst_drop", drop_count, 0);
    check("t6_rst_valid", bus.m_udpdata_tvalid, 0);
    areset = 1'b0;
    spi_byte(8'h04); spi_byte(8'h05); spi_byte(8'h06);
    repeat (HALF) @(negedge aclk);
    cs_b = 1'b1;
    repeat (30) @(negedge aclk);
    check("t6_nhdr", hdr_q.size(), 0);
    check("t6_ndat", dat_q.size(), 0);
    tx.delete();
    for (int k = 0; k < 8; k++) tx.push_back(8'(8'hA0 + k));
    spi_packet(0);
    wait_out(1, 1, "t6b");
    check("t6b_hdr", hdr_q[0], 64'h0A00_5678_0000_0010);
    check("t6b_w0", dat_q[0], {1'b1, 8'hFF, 64'hA7A6_A5A4_A3A2_A1A0});
    check("t6b_pkt", pkt_count, 1);
    check("t6b_drop", drop_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
